// File: rtl/msrv32_load_unit_mis.sv
// msrv32_load_unit_mis
// Sequential load unit for the msrv32 memory stage. It accepts one load
// request, issues one or two aligned reads on the data bus, merges and
// shifts the returned bytes, and produces a sign- or zero-extended result.
// Misaligned loads that cross a bus-word boundary take two beats. With
// MISALIGN_EN=0 they are reported as errors instead.
//
// Parameters
//   XLEN         data/address width, 32 or 64 (bus word = XLEN/8 bytes)
//   MISALIGN_EN  1 = split misaligned loads in hardware, 0 = flag them
// Ports
//   ms_riscv32_mp_clk_in      clock, rising edge
//   ms_riscv32_mp_rst_in      asynchronous active-low reset
//   load_req_in               request valid, taken when lu_busy_out=0
//   load_addr_in              byte address
//   load_size_in              0 byte, 1 half, 2 word, 3 double
//   load_unsigned_in          1 = zero-extend the result
//   ms_riscv32_mp_dmreq_out   bus read request
//   ms_riscv32_mp_dmaddr_out  bus-word aligned read address
//   ahb_ready_in              beat completes when high with dmreq_out
//   ahb_resp_in               error response, valid with ready
//   ms_riscv32_mp_dmdata_in   read data, valid with ready
//   lu_output_out             extended load result
//   lu_valid_out              one-cycle completion pulse
//   lu_busy_out               a bus beat is outstanding
//   lu_misaligned_err_out     misalignment error, qualified by valid
//   lu_bus_err_out            bus error, qualified by valid

module msrv32_load_unit_mis #(
    parameter int XLEN        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            load_req_in,
    input  logic [XLEN-1:0] load_addr_in,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    output logic            ms_riscv32_mp_dmreq_out,
    output logic [XLEN-1:0] ms_riscv32_mp_dmaddr_out,
    input  logic            ahb_ready_in,
    input  logic            ahb_resp_in,
    input  logic [XLEN-1:0] ms_riscv32_mp_dmdata_in,
    output logic [XLEN-1:0] lu_output_out,
    output logic            lu_valid_out,
    output logic            lu_busy_out,
    output logic            lu_misaligned_err_out,
    output logic            lu_bus_err_out
);

    localparam int BUS_BYTES = XLEN / 8;
    localparam int OFFW      = $clog2(BUS_BYTES);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t          state;
    state_t          next_state;

    logic            accept;
    logic [2:0]      req_off;
    logic            req_misaligned;
    logic            req_cross;
    logic            req_err;

    logic [OFFW-1:0] off_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            cross_q;
    logic [XLEN-1:0] beat0_q;
    logic [XLEN-1:0] dmaddr_q;
    logic [XLEN-1:0] result_q;
    logic            mis_err_q;
    logic            bus_err_q;

    logic [XLEN-1:0] merge_lo;
    logic [XLEN-1:0] merge_hi;
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] fill;
    logic [XLEN-1:0] extended;
    logic            sign;

    // Classify the incoming request. The offset is zero-extended to three
    // bits so one decode serves both bus widths. A double on a 32-bit unit
    // can never be serviced, so it always counts as a misalignment error.
    always_comb begin
        req_off = 3'(load_addr_in[OFFW-1:0]);
        unique case (load_size_in)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_off[0];
            2'd2:    req_misaligned = |req_off[1:0];
            default: req_misaligned = (XLEN == 32) ? 1'b1 : |req_off;
        endcase
        req_cross = ({1'b0, req_off} + (4'd1 << load_size_in)) > 4'(BUS_BYTES);
        req_err   = req_misaligned &&
                    (!MISALIGN_EN || (XLEN == 32 && load_size_in == 2'd3));
        accept    = load_req_in && (state == IDLE || state == DONE);
    end

    // State register; reset aborts any transfer and drops the bus request.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. IDLE and DONE both accept, which gives back-to-back
    // loads. An error response on the first beat skips the second beat.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: begin
                if (load_req_in) begin
                    next_state = req_err ? DONE : BEAT0;
                end else begin
                    next_state = IDLE;
                end
            end
            BEAT0: begin
                if (ahb_ready_in) begin
                    next_state = (!ahb_resp_in && cross_q) ? BEAT1 : DONE;
                end
            end
            BEAT1: begin
                if (ahb_ready_in) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control outputs decode straight from the state flops.
    always_comb begin
        ms_riscv32_mp_dmreq_out = (state == BEAT0) || (state == BEAT1);
        lu_busy_out             = (state == BEAT0) || (state == BEAT1);
        lu_valid_out            = (state == DONE);
    end

    // Merge and extend. The final beat is always the live bus data. On a
    // crossing load the first beat comes from beat0_q and becomes the low
    // half. A full-width load needs no extension, so its mask is all ones.
    always_comb begin
        merge_lo = (state == BEAT1) ? beat0_q : ms_riscv32_mp_dmdata_in;
        merge_hi = (state == BEAT1) ? ms_riscv32_mp_dmdata_in : '0;
        low      = XLEN'({merge_hi, merge_lo} >> {off_q, 3'b000});
        unique case (size_q)
            2'd0: begin
                mask = XLEN'(8'hFF);
                sign = low[7];
            end
            2'd1: begin
                mask = XLEN'(16'hFFFF);
                sign = low[15];
            end
            2'd2: begin
                mask = (XLEN == 64) ? XLEN'(32'hFFFF_FFFF) : '1;
                sign = low[31];
            end
            default: begin
                mask = '1;
                sign = 1'b0;
            end
        endcase
        fill     = (sign && !uns_q) ? '1 : '0;
        extended = (low & mask) | (fill & ~mask);
    end

    // Datapath registers. The result and error flags are written only on
    // the edge that enters DONE, so they hold until the next completion.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            cross_q   <= 1'b0;
            beat0_q   <= '0;
            dmaddr_q  <= '0;
            result_q  <= '0;
            mis_err_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else if (accept) begin
            off_q   <= load_addr_in[OFFW-1:0];
            size_q  <= load_size_in;
            uns_q   <= load_unsigned_in;
            cross_q <= req_cross;
            if (req_err) begin
                result_q  <= '0;
                mis_err_q <= 1'b1;
                bus_err_q <= 1'b0;
            end else begin
                dmaddr_q <= load_addr_in & ~XLEN'(BUS_BYTES - 1);
            end
        end else if ((state == BEAT0 || state == BEAT1) && ahb_ready_in) begin
            if (ahb_resp_in) begin
                result_q  <= '0;
                mis_err_q <= 1'b0;
                bus_err_q <= 1'b1;
            end else if (state == BEAT0 && cross_q) begin
                beat0_q  <= ms_riscv32_mp_dmdata_in;
                dmaddr_q <= dmaddr_q + XLEN'(BUS_BYTES);
            end else begin
                result_q  <= extended;
                mis_err_q <= 1'b0;
                bus_err_q <= 1'b0;
            end
        end
    end

    assign ms_riscv32_mp_dmaddr_out = dmaddr_q;
    assign lu_output_out            = result_q;
    assign lu_misaligned_err_out    = mis_err_q;
    assign lu_bus_err_out           = bus_err_q;

endmodule

// File: tb/tb_msrv32_load_unit_mis.sv
// tb_msrv32_load_unit_mis
// Bench for msrv32_load_unit_mis. Three instances are used: a 32-bit unit
// with hardware misalignment, a 32-bit unit that reports misalignment, and a
// 64-bit unit. Expected results are pushed into per-instance queues when a
// load is issued. Monitors pop and compare on every lu_valid_out. Bus
// responders model the memory and check beat addresses, wait-state
// stability and unexpected beats.

module tb_msrv32_load_unit_mis;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [63:0] data;
        logic        mis;
        logic        bus;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        q32[$];
    exp_t        qn[$];
    exp_t        q64[$];
    exp_t        ea;
    exp_t        en;
    exp_t        ew;
    logic [31:0] exp_addr32[$];
    int          wait32 = 0;
    logic        err32 = 1'b0;
    int          beats_n = 0;

    // instance a: XLEN=32, misaligned handled
    logic        req_a = 0, uns_a = 0, ready_a = 0, resp_a = 0;
    logic [31:0] addr_a = 0, rdata_a = 0;
    logic [1:0]  size_a = 0;
    logic        dmreq_a, valid_a, busy_a, mis_a, bus_a;
    logic [31:0] dmaddr_a, out_a;

    // instance n: XLEN=32, misaligned reported
    logic        req_n = 0, uns_n = 0, ready_n = 0, resp_n = 0;
    logic [31:0] addr_n = 0, rdata_n = 0;
    logic [1:0]  size_n = 0;
    logic        dmreq_n, valid_n, busy_n, mis_n, bus_n;
    logic [31:0] dmaddr_n, out_n;

    // instance w: XLEN=64, misaligned handled
    logic        req_w = 0, uns_w = 0, ready_w = 0, resp_w = 0;
    logic [63:0] addr_w = 0, rdata_w = 0;
    logic [1:0]  size_w = 0;
    logic        dmreq_w, valid_w, busy_w, mis_w, bus_w;
    logic [63:0] dmaddr_w, out_w;

    msrv32_load_unit_mis #(.XLEN(32), .MISALIGN_EN(1'b1)) dut_a (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
        .load_req_in(req_a), .load_addr_in(addr_a), .load_size_in(size_a),
        .load_unsigned_in(uns_a), .ms_riscv32_mp_dmreq_out(dmreq_a),
        .ms_riscv32_mp_dmaddr_out(dmaddr_a), .ahb_ready_in(ready_a),
        .ahb_resp_in(resp_a), .ms_riscv32_mp_dmdata_in(rdata_a),
        .lu_output_out(out_a), .lu_valid_out(valid_a), .lu_busy_out(busy_a),
        .lu_misaligned_err_out(mis_a), .lu_bus_err_out(bus_a));

    msrv32_load_unit_mis #(.XLEN(32), .MISALIGN_EN(1'b0)) dut_n (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
        .load_req_in(req_n), .load_addr_in(addr_n), .load_size_in(size_n),
        .load_unsigned_in(uns_n), .ms_riscv32_mp_dmreq_out(dmreq_n),
        .ms_riscv32_mp_dmaddr_out(dmaddr_n), .ahb_ready_in(ready_n),
        .ahb_resp_in(resp_n), .ms_riscv32_mp_dmdata_in(rdata_n),
        .lu_output_out(out_n), .lu_valid_out(valid_n), .lu_busy_out(busy_n),
        .lu_misaligned_err_out(mis_n), .lu_bus_err_out(bus_n));

    msrv32_load_unit_mis #(.XLEN(64), .MISALIGN_EN(1'b1)) dut_w (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
        .load_req_in(req_w), .load_addr_in(addr_w), .load_size_in(size_w),
        .load_unsigned_in(uns_w), .ms_riscv32_mp_dmreq_out(dmreq_w),
        .ms_riscv32_mp_dmaddr_out(dmaddr_w), .ahb_ready_in(ready_w),
        .ahb_resp_in(resp_w), .ms_riscv32_mp_dmdata_in(rdata_w),
        .lu_output_out(out_w), .lu_valid_out(valid_w), .lu_busy_out(busy_w),
        .lu_misaligned_err_out(mis_w), .lu_bus_err_out(bus_w));

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem32(input logic [31:0] a);
        case (a)
            32'h100: return 32'hDDCC_BBAA;
            32'h104: return 32'h1122_3344;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] mem64(input logic [63:0] a);
        case (a)
            64'h100: return 64'h8877_6655_4433_2211;
            64'h108: return 64'h0000_0000_0000_00FF;
            default: return 64'h0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic checkEntry(input string tag, input exp_t e,
                              input logic [63:0] out, input logic mis,
                              input logic bus);
        checkOutput({tag, "_data"}, out, e.data);
        checkOutput({tag, "_mis_err"}, 64'(mis), 64'(e.mis));
        checkOutput({tag, "_bus_err"}, 64'(bus), 64'(e.bus));
        checkOutput({tag, "_latency"}, 64'(cyc - e.issue), 64'(e.lat));
    endtask

    // Monitors: every valid pulse must match the oldest outstanding load.
    always @(negedge clk) begin
        if (valid_a) begin
            if (q32.size() == 0) checkOutput("a_unexpected_valid", 64'd1, 64'd0);
            else begin
                ea = q32.pop_front();
                checkEntry("a", ea, 64'(out_a), mis_a, bus_a);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_n) begin
            if (qn.size() == 0) checkOutput("n_unexpected_valid", 64'd1, 64'd0);
            else begin
                en = qn.pop_front();
                checkEntry("n", en, 64'(out_n), mis_n, bus_n);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_w) begin
            if (q64.size() == 0) checkOutput("w_unexpected_valid", 64'd1, 64'd0);
            else begin
                ew = q64.pop_front();
                checkEntry("w", ew, out_w, mis_w, bus_w);
            end
        end
    end

    // Bus responder for instance a: optional wait states and error on the
    // next beat; every completed beat must hit the next expected address.
    always @(negedge clk) begin
        ready_a = 1'b0;
        resp_a  = 1'b0;
        rdata_a = mem32(dmaddr_a);
        if (dmreq_a) begin
            if (wait32 > 0) begin
                wait32--;
                checkOutput("a_busy_in_wait", 64'(busy_a), 64'd1);
                if (exp_addr32.size() > 0)
                    checkOutput("a_addr_stable", 64'(dmaddr_a), 64'(exp_addr32[0]));
            end else begin
                ready_a = 1'b1;
                resp_a  = err32;
                err32   = 1'b0;
                if (exp_addr32.size() == 0)
                    checkOutput("a_unexpected_beat", 64'd1, 64'd0);
                else
                    checkOutput("a_beat_addr", 64'(dmaddr_a), 64'(exp_addr32.pop_front()));
            end
        end
    end

    // Zero-wait responders for instances n and w.
    always @(negedge clk) begin
        ready_n = dmreq_n;
        resp_n  = 1'b0;
        rdata_n = mem32(dmaddr_n);
        if (dmreq_n) beats_n++;
        ready_w = dmreq_w;
        resp_w  = 1'b0;
        rdata_w = mem64(dmaddr_w);
    end

    // Issue one request; called at a negedge, returns one negedge later.
    task automatic applyStimulus(input int dut, input logic [63:0] addr,
                                 input logic [1:0] size, input logic uns,
                                 input logic [63:0] edata, input logic emis,
                                 input logic ebus, input int lat);
        exp_t e;
        e.data  = edata;
        e.mis   = emis;
        e.bus   = ebus;
        e.issue = cyc;
        e.lat   = lat;
        case (dut)
            0: begin q32.push_back(e); req_a = 1; addr_a = addr[31:0]; size_a = size; uns_a = uns; end
            1: begin qn.push_back(e);  req_n = 1; addr_n = addr[31:0]; size_n = size; uns_n = uns; end
            default: begin q64.push_back(e); req_w = 1; addr_w = addr; size_w = size; uns_w = uns; end
        endcase
        @(negedge clk);
        req_a = 0;
        req_n = 0;
        req_w = 0;
    endtask

    task automatic waitDone(input int dut);
        int   k = 0;
        logic v;
        v = (dut == 0) ? valid_a : (dut == 1) ? valid_n : valid_w;
        while (!v && k < 20) begin
            @(negedge clk);
            k++;
            v = (dut == 0) ? valid_a : (dut == 1) ? valid_n : valid_w;
        end
        if (!v) checkOutput("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic load(input int dut, input logic [63:0] addr,
                        input logic [1:0] size, input logic uns,
                        input logic [63:0] edata, input logic emis,
                        input logic ebus, input int lat);
        applyStimulus(dut, addr, size, uns, edata, emis, ebus, lat);
        waitDone(dut);
        @(negedge clk);
    endtask

    task automatic setBeats(input logic [31:0] a0, input int n);
        exp_addr32.push_back(a0);
        if (n == 2) exp_addr32.push_back(a0 + 32'd4);
    endtask

    initial begin
        int b;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_a_output", 64'(out_a), 64'd0);
        checkOutput("rst_a_valid", 64'(valid_a), 64'd0);
        checkOutput("rst_a_dmreq", 64'(dmreq_a), 64'd0);
        checkOutput("rst_a_dmaddr", 64'(dmaddr_a), 64'd0);
        checkOutput("rst_a_busy", 64'(busy_a), 64'd0);
        checkOutput("rst_a_errs", 64'({mis_a, bus_a}), 64'd0);
        checkOutput("rst_w_output", out_w, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 32-bit unit, misaligned loads split in hardware
        setBeats(32'h100, 1); load(0, 64'h101, 2'd0, 1'b0, 64'hFFFF_FFBB, 0, 0, 2);
        checkOutput("a_output_hold", 64'(out_a), 64'hFFFF_FFBB);
        setBeats(32'h100, 1); load(0, 64'h101, 2'd0, 1'b1, 64'h0000_00BB, 0, 0, 2);
        setBeats(32'h100, 2); load(0, 64'h103, 2'd1, 1'b0, 64'h0000_44DD, 0, 0, 3);
        setBeats(32'h100, 2); load(0, 64'h102, 2'd2, 1'b0, 64'h3344_DDCC, 0, 0, 3);
        setBeats(32'h100, 1); load(0, 64'h101, 2'd1, 1'b0, 64'hFFFF_CCBB, 0, 0, 2);
        setBeats(32'h100, 1); wait32 = 3;
        load(0, 64'h100, 2'd2, 1'b0, 64'hDDCC_BBAA, 0, 0, 5);
        setBeats(32'h100, 1); err32 = 1'b1;
        load(0, 64'h102, 2'd2, 1'b0, 64'h0, 0, 1, 2);
        load(0, 64'h100, 2'd3, 1'b0, 64'h0, 1, 0, 1);
        setBeats(32'h104, 2); load(0, 64'h107, 2'd1, 1'b0, 64'h0000_0011, 0, 0, 3);
        setBeats(32'h104, 1); setBeats(32'h104, 1);
        applyStimulus(0, 64'h106, 2'd1, 1'b1, 64'h0000_1122, 0, 0, 2);
        waitDone(0);
        load(0, 64'h104, 2'd0, 1'b0, 64'h0000_0044, 0, 0, 2);

        // reset while the second beat of a crossing load is on the bus
        setBeats(32'h100, 2);
        req_a = 1; addr_a = 32'h102; size_a = 2'd2; uns_a = 1'b0;
        @(negedge clk);
        req_a = 0;
        @(negedge clk);
        checkOutput("a_dmreq_in_beat1", 64'(dmreq_a), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("a_rst_dmreq_drop", 64'(dmreq_a), 64'd0);
        checkOutput("a_rst_valid", 64'(valid_a), 64'd0);
        checkOutput("a_rst_output", 64'(out_a), 64'd0);
        checkOutput("a_rst_dmaddr", 64'(dmaddr_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr32.delete();
        repeat (3) @(negedge clk);
        setBeats(32'h100, 1); load(0, 64'h100, 2'd2, 1'b0, 64'hDDCC_BBAA, 0, 0, 2);

        // 32-bit unit that reports misalignment
        b = beats_n;
        load(1, 64'h102, 2'd2, 1'b0, 64'h0, 1, 0, 1);
        checkOutput("n_no_dmreq", 64'(beats_n), 64'(b));
        load(1, 64'h101, 2'd1, 1'b0, 64'h0, 1, 0, 1);
        load(1, 64'h104, 2'd2, 1'b0, 64'h1122_3344, 0, 0, 2);

        // 64-bit unit
        load(2, 64'h104, 2'd2, 1'b0, 64'hFFFF_FFFF_8877_6655, 0, 0, 2);
        load(2, 64'h104, 2'd2, 1'b1, 64'h0000_0000_8877_6655, 0, 0, 2);
        load(2, 64'h107, 2'd3, 1'b0, 64'h0000_0000_0000_FF88, 0, 0, 3);
        load(2, 64'h107, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF88, 0, 0, 2);
        load(2, 64'h107, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FF88, 0, 0, 3);
        load(2, 64'h108, 2'd3, 1'b0, 64'h0000_0000_0000_00FF, 0, 0, 2);

        repeat (3) @(negedge clk);
        checkOutput("a_queue_drained", 64'(q32.size()), 64'd0);
        checkOutput("n_queue_drained", 64'(qn.size()), 64'd0);
        checkOutput("w_queue_drained", 64'(q64.size()), 64'd0);
        checkOutput("a_beats_drained", 64'(exp_addr32.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
